// File: rtl/window_5x5_gen.sv
// -----------------------------------------------------------------------------
// window_5x5_gen
//
// Streaming 5x5 neighbourhood generator. Pixels arrive in raster order from an
// upstream FIFO. Each fully valid interior position (row >= 4, col >= 4 of the
// pixel just read) produces one packed 25-pixel window, pushed to a downstream
// FIFO. No border padding: edge positions produce nothing.
//
// Packing: element k = r*5 + c sits at out_din[k*PIX_WIDTH +: PIX_WIDTH].
//   r = 0 is the top (oldest) row, c = 0 the leftmost (oldest) column, so
//   element 24 is the pixel read on the cycle that completed the window.
//
// Ports
//   clock      in   single clock, all logic on the rising edge
//   reset      in   synchronous, active-high
//   in_dout    in   pixel at the head of the upstream FIFO
//   in_empty   in   upstream FIFO empty
//   in_rd_en   out  pop upstream FIFO; in_dout is consumed on this edge
//   out_full   in   downstream FIFO full
//   out_wr_en  out  push out_din on this edge
//   out_din    out  packed 5x5 window (DWIDTH_OUT bits)
// -----------------------------------------------------------------------------
module window_5x5_gen #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int PIX_WIDTH  = 8,
  parameter int DWIDTH_OUT = PIX_WIDTH * 25
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PIX_WIDTH-1:0]  in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DWIDTH_OUT-1:0] out_din
);

  // ---------------------------------------------------------------------------
  // Counter geometry
  // ---------------------------------------------------------------------------
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FOUR = COL_W'(4);
  localparam logic [ROW_W-1:0] ROW_FOUR = ROW_W'(4);

  // ---------------------------------------------------------------------------
  // FSM encoding
  //   RUN  : accumulating pixels, no window pending
  //   EMIT : window register holds a complete window awaiting the push
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]           r_state;
  logic [ROW_W-1:0]     r_row;
  logic [COL_W-1:0]     r_col;

  // Line buffers: lb0 holds the most recent previous row, lb3 the oldest.
  logic [PIX_WIDTH-1:0] r_lb0 [0:IMG_WIDTH-1];
  logic [PIX_WIDTH-1:0] r_lb1 [0:IMG_WIDTH-1];
  logic [PIX_WIDTH-1:0] r_lb2 [0:IMG_WIDTH-1];
  logic [PIX_WIDTH-1:0] r_lb3 [0:IMG_WIDTH-1];

  // Window register, indexed by packed element number k = r*5 + c.
  logic [PIX_WIDTH-1:0] r_win [0:24];

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_qualify;
  logic                 w_col_last;
  logic                 w_row_last;
  logic [PIX_WIDTH-1:0] w_tap [0:4];   // new right column, top to bottom

  // NOTE: every signal driven in an always_comb gets a value on every path
  // (defaults first); a missed branch would otherwise infer a latch.
  always_comb begin
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_qualify  = 1'b0;
    w_col_last = 1'b0;
    w_row_last = 1'b0;

    // Holding both FIFO strobes low while reset is high keeps a pixel from
    // being popped (and lost) or a stale window pushed during reset.
    if (!reset) begin
      w_wr = (r_state == ST_EMIT) && !out_full;
      // In EMIT a read is only allowed together with the write, so a stalled
      // window is never overwritten by the shift.
      w_rd = !in_empty && ((r_state == ST_RUN) || !out_full);
    end

    // Qualification uses the counters of the pixel being read right now.
    w_qualify  = (r_row >= ROW_FOUR) && (r_col >= COL_FOUR);
    w_col_last = (r_col == COL_LAST);
    w_row_last = (r_row == ROW_LAST);

    // Column entering the window: four stored rows above, live pixel below.
    w_tap[0] = r_lb3[r_col];
    w_tap[1] = r_lb2[r_col];
    w_tap[2] = r_lb1[r_col];
    w_tap[3] = r_lb0[r_col];
    w_tap[4] = in_dout;
  end

  assign in_rd_en  = w_rd;
  assign out_wr_en = w_wr;

  // ---------------------------------------------------------------------------
  // Line buffers
  // ---------------------------------------------------------------------------
  // NOTE: the line buffers have no reset. Their contents are never emitted
  // until four fresh rows have passed through them, and leaving them out of
  // reset lets them map onto RAM instead of flops.
  always_ff @(posedge clock) begin
    if (w_rd) begin
      // Each column slot ages by one row: the whole column moves down.
      r_lb3[r_col] <= r_lb2[r_col];
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= in_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // Window register, counters and FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the pre-edge value (the window shift and the
  // line-buffer rotation depend on that).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_row   <= '0;
      r_col   <= '0;
      for (int k = 0; k < 25; k++) begin
        r_win[k] <= '0;
      end
    end else begin
      if (w_rd) begin
        // Shift every row left by one column and load the new right column.
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            r_win[r*5 + c] <= r_win[r*5 + c + 1];
          end
          r_win[r*5 + 4] <= w_tap[r];
        end

        // Raster position of the next pixel; wraps at frame end with no
        // flush, qualification keeps stale rows out of the output.
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      // A qualifying read always leads to EMIT (even from EMIT, where the
      // current window is pushed on this same edge). Otherwise, a completed
      // push, or no window at all, leaves the FSM in RUN.
      if (w_rd) begin
        r_state <= w_qualify ? ST_EMIT : ST_RUN;
      end else if (w_wr) begin
        r_state <= ST_RUN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < 25; k++) begin : g_pack
    assign out_din[k*PIX_WIDTH +: PIX_WIDTH] = r_win[k];
  end

endmodule

// File: tb/tb_window_5x5_gen.sv
// -----------------------------------------------------------------------------
// tb_window_5x5_gen
//
// Drives window_5x5_gen with raster frames and compares every pushed window
// with a reference built directly from the frame contents: for every pixel
// position (row, col) with row >= 4 and col >= 4, the 5x5 block whose
// bottom-right corner is (row, col), in raster order.
// -----------------------------------------------------------------------------
module tb_window_5x5_gen;

  typedef logic [199:0] win_t;

  localparam int SW = 8;    // small frame width
  localparam int SH = 6;    // small frame height
  localparam int LW = 40;   // larger, non-power-of-two frame width
  localparam int LH = 30;   // larger frame height

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   in_dout;
  logic         in_empty;
  logic         in_rd_en;
  logic         out_full;
  logic         out_wr_en;
  logic [199:0] out_din;

  logic         l_reset;
  logic [7:0]   l_in_dout;
  logic         l_in_empty;
  logic         l_in_rd_en;
  logic         l_out_full;
  logic         l_out_wr_en;
  logic [199:0] l_out_din;

  always #5 clock = ~clock;

  window_5x5_gen #(
    .IMG_WIDTH (SW),
    .IMG_HEIGHT(SH),
    .PIX_WIDTH (8)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .in_dout  (in_dout),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .out_full (out_full),
    .out_wr_en(out_wr_en),
    .out_din  (out_din)
  );

  window_5x5_gen #(
    .IMG_WIDTH (LW),
    .IMG_HEIGHT(LH),
    .PIX_WIDTH (8)
  ) u_dut_large (
    .clock    (clock),
    .reset    (l_reset),
    .in_dout  (l_in_dout),
    .in_empty (l_in_empty),
    .in_rd_en (l_in_rd_en),
    .out_full (l_out_full),
    .out_wr_en(l_out_wr_en),
    .out_din  (l_out_din)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src_q[$];
  win_t       exp_q[$];
  win_t       got_q[$];
  logic [7:0] l_src_q[$];
  win_t       l_exp_q[$];
  win_t       l_got_q[$];

  int rd_total;      // pixels consumed since the last reset
  int first_wr_rd;   // rd_total observed on the cycle of the first push
  int proto_err;     // reads while empty or pushes while full

  // ---------------------------------------------------------------------------
  // Reference model: frame contents -> pixel stream + expected windows
  //   kind 0: row*16+col, kind 1: 0xFF-(row*16+col), other: random
  // ---------------------------------------------------------------------------
  task automatic load_frame(input int sel, input int kind, input int h, input int w);
    int   frm [0:LH-1][0:LW-1];
    win_t wv;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        case (kind)
          0:       frm[r][c] = r*16 + c;
          1:       frm[r][c] = 255 - (r*16 + c);
          default: frm[r][c] = int'($urandom_range(0, 255));
        endcase
        if (sel == 0) src_q.push_back(8'(frm[r][c]));
        else          l_src_q.push_back(8'(frm[r][c]));
      end
    end
    for (int r = 4; r < h; r++) begin
      for (int c = 4; c < w; c++) begin
        wv = '0;
        for (int wr = 0; wr < 5; wr++) begin
          for (int wc = 0; wc < 5; wc++) begin
            wv[(wr*5 + wc)*8 +: 8] = 8'(frm[r-4+wr][c-4+wc]);
          end
        end
        if (sel == 0) exp_q.push_back(wv);
        else          l_exp_q.push_back(wv);
      end
    end
  endtask

  function automatic int mism(input int sel);
    int m = 0;
    int n;
    if (sel == 0) begin
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) m++;
    end else begin
      n = (l_got_q.size() < l_exp_q.size()) ? l_got_q.size() : l_exp_q.size();
      for (int i = 0; i < n; i++) if (l_got_q[i] !== l_exp_q[i]) m++;
    end
    return m;
  endfunction

  function automatic logic [7:0] elem(input win_t w, input int k);
    return w[k*8 +: 8];
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle drivers: inputs change on the falling edge, outputs sampled 1 ns
  // later (well before the next rising edge).
  // ---------------------------------------------------------------------------
  task automatic step(input int p_empty, input int p_full);
    @(negedge clock);
    in_empty = (src_q.size() == 0) || (int'($urandom_range(0, 99)) < p_empty);
    out_full = (int'($urandom_range(0, 99)) < p_full);
    in_dout  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    #1;
    if (in_rd_en && in_empty) proto_err++;
    if (out_wr_en && out_full) proto_err++;
    if (out_wr_en) begin
      if (got_q.size() == 0) first_wr_rd = rd_total;
      got_q.push_back(out_din);
    end
    if (in_rd_en) begin
      void'(src_q.pop_front());
      rd_total++;
    end
  endtask

  task automatic l_step(input int p_empty, input int p_full);
    @(negedge clock);
    l_in_empty = (l_src_q.size() == 0) || (int'($urandom_range(0, 99)) < p_empty);
    l_out_full = (int'($urandom_range(0, 99)) < p_full);
    l_in_dout  = (l_src_q.size() != 0) ? l_src_q[0] : 8'h00;
    #1;
    if (l_in_rd_en && l_in_empty) proto_err++;
    if (l_out_wr_en && l_out_full) proto_err++;
    if (l_out_wr_en) l_got_q.push_back(l_out_din);
    if (l_in_rd_en) void'(l_src_q.pop_front());
  endtask

  // Steps until n windows are collected (or the budget runs out), then a few
  // idle cycles so a duplicated push would still be caught.
  task automatic run_until(input int n, input int p_empty, input int p_full,
                           input int budget, output bit timed_out);
    int cyc = 0;
    while (got_q.size() < n && cyc < budget) begin
      step(p_empty, p_full);
      cyc++;
    end
    timed_out = (got_q.size() < n);
    repeat (10) step(0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b1;
    out_full = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    rd_total    = 0;
    first_wr_rd = -1;
    proto_err   = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b0;
    out_full = 1'b0;
    in_dout  = 8'hA5;
    @(negedge clock);
    #1;
    n_tests++;
    if (in_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", in_rd_en); end
    n_tests++;
    if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", out_wr_en); end
    n_tests++;
    if (out_din !== 200'h0) begin n_fail++; $display("FAIL reset_out_din: got %h expected 0", out_din); end
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;
    #1;
    n_tests++;
    if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_wr_en: got %b expected 0", out_wr_en); end
  endtask

  task automatic test_first_window();
    bit   to;
    win_t g;
    do_reset();
    load_frame(0, 0, SH, SW);
    run_until(8, 0, 0, 400, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL first_timeout: got %0d windows expected 8", got_q.size()); end
    n_tests++;
    if (first_wr_rd !== 37) begin n_fail++; $display("FAIL first_latency: first push after %0d reads expected 37", first_wr_rd); end
    n_tests++;
    if (got_q.size() !== 8) begin n_fail++; $display("FAIL first_count: got %0d expected 8", got_q.size()); end
    g = (got_q.size() > 0) ? got_q[0] : '0;
    n_tests++;
    if (elem(g, 0) !== 8'h00 || elem(g, 24) !== 8'h44) begin
      n_fail++; $display("FAIL first_elems: got e0=%h e24=%h expected e0=00 e24=44", elem(g, 0), elem(g, 24));
    end
    g = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
    n_tests++;
    if (elem(g, 24) !== 8'h57) begin n_fail++; $display("FAIL last_elem24: got %h expected 57", elem(g, 24)); end
    n_tests++;
    if (mism(0) !== 0) begin n_fail++; $display("FAIL first_windows: got %0d mismatching windows expected 0", mism(0)); end
    n_tests++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL first_protocol: got %0d violations expected 0", proto_err); end
  endtask

  task automatic test_backpressure();
    bit   to;
    int   cyc = 0;
    int   stall_err = 0;
    win_t held;
    do_reset();
    load_frame(0, 0, SH, SW);
    while (rd_total < 37 && cyc < 200) begin
      step(0, 0);
      cyc++;
    end
    held = exp_q[0];
    // The DUT now holds its first window; keep the downstream FIFO full.
    repeat (5) begin
      step(0, 100);
      if (out_wr_en !== 1'b0 || in_rd_en !== 1'b0 || out_din !== held) stall_err++;
    end
    n_tests++;
    if (stall_err !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad stall cycles expected 0", stall_err); end
    run_until(8, 0, 0, 400, to);
    n_tests++;
    if (got_q.size() !== 8) begin n_fail++; $display("FAIL stall_count: got %0d expected 8", got_q.size()); end
    n_tests++;
    if (mism(0) !== 0) begin n_fail++; $display("FAIL stall_windows: got %0d mismatching windows expected 0", mism(0)); end
  endtask

  task automatic test_random();
    bit to;
    do_reset();
    repeat (3) load_frame(0, 2, SH, SW);
    run_until(24, 50, 30, 3000, to);
    n_tests++;
    if (got_q.size() !== 24) begin n_fail++; $display("FAIL random_count: got %0d expected 24", got_q.size()); end
    n_tests++;
    if (mism(0) !== 0) begin n_fail++; $display("FAIL random_windows: got %0d mismatching windows expected 0", mism(0)); end
    n_tests++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL random_protocol: got %0d violations expected 0", proto_err); end
  endtask

  task automatic test_back_to_back();
    bit   to;
    win_t g;
    do_reset();
    load_frame(0, 0, SH, SW);
    load_frame(0, 1, SH, SW);
    run_until(16, 0, 0, 600, to);
    n_tests++;
    if (got_q.size() !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d expected 16", got_q.size()); end
    g = (got_q.size() > 8) ? got_q[8] : '0;
    n_tests++;
    if (elem(g, 0) !== 8'hFF || elem(g, 24) !== 8'hBB) begin
      n_fail++; $display("FAIL b2b_elems: got e0=%h e24=%h expected e0=ff e24=bb", elem(g, 0), elem(g, 24));
    end
    n_tests++;
    if (mism(0) !== 0) begin n_fail++; $display("FAIL b2b_windows: got %0d mismatching windows expected 0", mism(0)); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int cyc = 0;
    do_reset();
    load_frame(0, 0, SH, SW);
    while (got_q.size() < 3 && cyc < 400) begin
      step(0, 0);
      cyc++;
    end
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b0;
    out_full = 1'b0;
    #1;
    n_tests++;
    if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_strobes: got rd=%b wr=%b expected 0 0", in_rd_en, out_wr_en);
    end
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;
    #1;
    n_tests++;
    if (out_wr_en !== 1'b0 || out_din !== 200'h0) begin
      n_fail++; $display("FAIL mid_reset_after: got wr=%b din=%h expected 0 0", out_wr_en, out_din);
    end
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    rd_total    = 0;
    first_wr_rd = -1;
    load_frame(0, 2, SH, SW);
    run_until(8, 0, 0, 400, to);
    n_tests++;
    if (first_wr_rd !== 37) begin n_fail++; $display("FAIL mid_reset_latency: first push after %0d reads expected 37", first_wr_rd); end
    n_tests++;
    if (got_q.size() !== 8) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 8", got_q.size()); end
    n_tests++;
    if (mism(0) !== 0) begin n_fail++; $display("FAIL mid_reset_windows: got %0d mismatching windows expected 0", mism(0)); end
  endtask

  task automatic test_large_frame();
    int   cyc = 0;
    int   n_exp;
    int   centre;
    win_t g;
    win_t e;
    @(negedge clock);
    l_reset = 1'b1;
    @(negedge clock);
    l_reset   = 1'b0;
    proto_err = 0;
    load_frame(1, 2, LH, LW);
    n_exp = (LW - 4) * (LH - 4);
    while (l_got_q.size() < n_exp && cyc < 6000) begin
      l_step(20, 20);
      cyc++;
    end
    repeat (10) l_step(0, 0);
    n_tests++;
    if (l_got_q.size() !== n_exp) begin n_fail++; $display("FAIL large_count: got %0d expected %0d", l_got_q.size(), n_exp); end
    n_tests++;
    if (mism(1) !== 0) begin n_fail++; $display("FAIL large_windows: got %0d mismatching windows expected 0", mism(1)); end
    // Window centred on (15,20) completes at the read of (17,22).
    centre = (17 - 4) * (LW - 4) + (22 - 4);
    g = (l_got_q.size() > centre) ? l_got_q[centre] : '0;
    e = l_exp_q[centre];
    n_tests++;
    if (elem(g, 12) !== elem(e, 12) || g !== e) begin
      n_fail++; $display("FAIL large_centre: got centre=%h expected %h", elem(g, 12), elem(e, 12));
    end
    n_tests++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL large_protocol: got %0d violations expected 0", proto_err); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    in_dout    = 8'h00;
    in_empty   = 1'b1;
    out_full   = 1'b0;
    l_reset    = 1'b1;
    l_in_dout  = 8'h00;
    l_in_empty = 1'b1;
    l_out_full = 1'b0;
    rd_total    = 0;
    first_wr_rd = -1;
    proto_err   = 0;
    repeat (2) @(negedge clock);

    test_reset();
    test_first_window();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_large_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
